tournament_branch_predictor: RTL and testbench

//  Fetch-side tournament predictor (local + gshare + chooser), trained by the decode-stage branch resolution.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_ctr_table.sv | 40 ++++
 rtl/tournament_branch_predictor.sv | 137 +++++++++++++
 tb/tb_tournament_branch_predictor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared state encoding, saturating-counter helpers and sizing helpers for the
// tournament branch predictor.
package bp_pkg;

    localparam int CTR_MAX_W = 8;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    function automatic ctr_t ctr_max(input int bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    // Reset value of every PHT and chooser entry: weakly-not-taken / weakly-local.
    function automatic ctr_t CTR_WEAK_NT(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t ctr_sat_inc(input ctr_t v, input int bits);
        return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

    function automatic int idx_max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_max4(input int a, input int b, input int c, input int d);
        return idx_max2(idx_max2(a, b), idx_max2(c, d));
    endfunction

endpackage

// File: rtl/bp_ctr_table.sv
// Saturating-counter table: one async read port (MSB only), one read-modify-write
// training port, and an init port that writes the weak value during the INIT sweep.
module bp_ctr_table
    import bp_pkg::*;
#(
    parameter int AW       = 8,
    parameter int CTR_BITS = 2
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_msb,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_up,
    input  logic          init_en,
    input  logic [AW-1:0] init_addr
);

    localparam int DEPTH = 1 << AW;

    logic [CTR_BITS-1:0] mem [DEPTH];
    logic [CTR_BITS-1:0] wr_old;
    logic [CTR_BITS-1:0] wr_new;

    assign rd_msb = mem[rd_addr][CTR_BITS-1];
    assign wr_old = mem[wr_addr];

    always_comb begin
        wr_new = wr_old;
        if (wr_up) wr_new = CTR_BITS'(ctr_sat_inc(ctr_t'(wr_old), CTR_BITS));
        else       wr_new = CTR_BITS'(ctr_sat_dec(ctr_t'(wr_old)));
    end

    // NOTE: the array has no reset branch; the INIT sweep writes every entry instead.
    always_ff @(posedge clk) begin
        if (init_en)    mem[init_addr] <= CTR_BITS'(CTR_WEAK_NT(CTR_BITS));
        else if (wr_en) mem[wr_addr]   <= wr_new;
    end

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament predictor (local + gshare + chooser) with speculative GHR and repair.
// Optional resolved/mispredict performance counters under BP_PERF_CNT_EN.
module tournament_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int GHR_LEN    = 8,
    parameter int LHT_AW     = 6,
    parameter int LHIST_LEN  = 8,
    parameter int CHOOSER_AW = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                F_ready_o,
    input  logic                F_fire_i,
    input  logic [PC_WIDTH-1:0] F_PC_i,
    output logic                F_predict_o,
    output logic                F_local_predict_o,
    output logic                F_global_predict_o,
    output logic [GHR_LEN-1:0]  F_ghr_o,
    input  logic                D_update_i,
    input  logic [PC_WIDTH-1:0] D_PC_i,
    input  logic [GHR_LEN-1:0]  D_ghr_i,
    input  logic                D_taken_i,
    input  logic                D_train_taken_i,
    input  logic                D_train_local_taken_i,
    input  logic                D_train_global_taken_i,
    output logic [31:0]         D_perf_branch_o,
    output logic [31:0]         D_perf_mispred_o
);

    localparam int IDX_W = idx_max4(LHT_AW, LHIST_LEN, GHR_LEN, CHOOSER_AW);

    bp_state_t            state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [GHR_LEN-1:0]   ghr;
    logic [LHIST_LEN-1:0] lht [1 << LHT_AW];

    logic run, init_en, upd, unused_pc;
    logic [LHT_AW-1:0]    f_lht_addr, d_lht_addr;
    logic [LHIST_LEN-1:0] f_hist, d_hist;
    logic [GHR_LEN-1:0]   f_gidx, d_gidx;
    logic l_msb, g_msb, sel_global;

    assign run       = (state == BP_RUN);
    assign init_en   = ~run;
    assign upd       = run & D_update_i;
    assign unused_pc = ^{F_PC_i, D_PC_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BP_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == BP_INIT) begin
            idx_nxt = idx + 1'b1;
            if (&idx) state_nxt = BP_RUN;
        end
    end

    assign f_lht_addr = F_PC_i[2 +: LHT_AW];
    assign d_lht_addr = D_PC_i[2 +: LHT_AW];
    assign f_hist     = lht[f_lht_addr];
    assign d_hist     = lht[d_lht_addr];
    assign f_gidx     = ghr ^ F_PC_i[2 +: GHR_LEN];
    assign d_gidx     = D_ghr_i ^ D_PC_i[2 +: GHR_LEN];

    always_ff @(posedge clk) begin
        if (init_en)  lht[idx[LHT_AW-1:0]] <= '0;
        else if (upd) lht[d_lht_addr]      <= {d_hist[LHIST_LEN-2:0], D_taken_i};
    end

    bp_ctr_table #(.AW(LHIST_LEN), .CTR_BITS(CTR_BITS)) u_lpht (
        .clk(clk), .rd_addr(f_hist), .rd_msb(l_msb),
        .wr_en(upd), .wr_addr(d_hist), .wr_up(D_taken_i),
        .init_en(init_en), .init_addr(idx[LHIST_LEN-1:0])
    );

    bp_ctr_table #(.AW(GHR_LEN), .CTR_BITS(CTR_BITS)) u_gpht (
        .clk(clk), .rd_addr(f_gidx), .rd_msb(g_msb),
        .wr_en(upd), .wr_addr(d_gidx), .wr_up(D_taken_i),
        .init_en(init_en), .init_addr(idx[GHR_LEN-1:0])
    );

    // The chooser only learns when exactly one component was right.
    bp_ctr_table #(.AW(CHOOSER_AW), .CTR_BITS(CTR_BITS)) u_chooser (
        .clk(clk), .rd_addr(F_PC_i[2 +: CHOOSER_AW]), .rd_msb(sel_global),
        .wr_en(upd & (D_train_local_taken_i ^ D_train_global_taken_i)),
        .wr_addr(D_PC_i[2 +: CHOOSER_AW]), .wr_up(D_train_global_taken_i),
        .init_en(init_en), .init_addr(idx[CHOOSER_AW-1:0])
    );

    assign F_ready_o          = run;
    assign F_local_predict_o  = run & l_msb;
    assign F_global_predict_o = run & g_msb;
    assign F_predict_o        = run & (sel_global ? g_msb : l_msb);
    assign F_ghr_o            = ghr;

    // NOTE: non-blocking so every flop samples pre-edge values of its neighbours.
    // A repair flushes the younger fetch, so it takes priority over the shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ghr <= '0;
        else if (upd && !D_train_taken_i) ghr <= {D_ghr_i[GHR_LEN-2:0], D_taken_i};
        else if (run && F_fire_i)         ghr <= {ghr[GHR_LEN-2:0], F_predict_o};
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branch, perf_mispred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branch  <= '0;
            perf_mispred <= '0;
        end else if (upd) begin
            perf_branch <= perf_branch + 32'd1;
            if (!D_train_taken_i) perf_mispred <= perf_mispred + 32'd1;
        end
    end

    assign D_perf_branch_o  = perf_branch;
    assign D_perf_mispred_o = perf_mispred;
`else
    assign D_perf_branch_o  = '0;
    assign D_perf_mispred_o = '0;
`endif

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Self-checking bench: directed vector table, hand sequences for chooser/perf/reset,
// and random traffic against an array-based behavioural model.
module tb_tournament_branch_predictor;

    localparam int INIT_CYCLES = 256;
    localparam int CMAX        = 3;
    localparam int TAKEN_TH    = 2;

    logic        clk, rst;
    logic        F_ready_o, F_fire_i, F_predict_o, F_local_predict_o, F_global_predict_o;
    logic [31:0] F_PC_i, D_PC_i;
    logic [7:0]  F_ghr_o, D_ghr_i;
    logic        D_update_i, D_taken_i, D_train_taken_i, D_train_local_taken_i, D_train_global_taken_i;
    logic [31:0] D_perf_branch_o, D_perf_mispred_o;

    tournament_branch_predictor dut (
        .clk(clk), .rst(rst), .F_ready_o(F_ready_o), .F_fire_i(F_fire_i), .F_PC_i(F_PC_i),
        .F_predict_o(F_predict_o), .F_local_predict_o(F_local_predict_o),
        .F_global_predict_o(F_global_predict_o), .F_ghr_o(F_ghr_o),
        .D_update_i(D_update_i), .D_PC_i(D_PC_i), .D_ghr_i(D_ghr_i), .D_taken_i(D_taken_i),
        .D_train_taken_i(D_train_taken_i), .D_train_local_taken_i(D_train_local_taken_i),
        .D_train_global_taken_i(D_train_global_taken_i),
        .D_perf_branch_o(D_perf_branch_o), .D_perf_mispred_o(D_perf_mispred_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_lpht [256];
    int m_gpht [256];
    int m_ch   [256];
    int m_lht  [64];
    int m_ghr, m_br, m_mis;

    function automatic void model_reset();
        foreach (m_lpht[i]) m_lpht[i] = 1;
        foreach (m_gpht[i]) m_gpht[i] = 1;
        foreach (m_ch[i])   m_ch[i]   = 1;
        foreach (m_lht[i])  m_lht[i]  = 0;
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic int bump(input int c, input bit up);
        if (up) return (c < CMAX) ? c + 1 : c;
        return (c > 0) ? c - 1 : c;
    endfunction

    function automatic int lidx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int cidx(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    function automatic int gidx(input int ghr, input logic [31:0] pc);
        return int'(((pc >> 2) ^ 32'(ghr)) % 256);
    endfunction

    function automatic bit m_local(input logic [31:0] pc);
        return m_lpht[m_lht[lidx(pc)]] >= TAKEN_TH;
    endfunction

    function automatic bit m_global(input logic [31:0] pc);
        return m_gpht[gidx(m_ghr, pc)] >= TAKEN_TH;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return (m_ch[cidx(pc)] >= TAKEN_TH) ? m_global(pc) : m_local(pc);
    endfunction

    function automatic int exp_perf(input int v);
`ifdef BP_PERF_CNT_EN
        return v;
`else
        return v * 0;
`endif
    endfunction

    // Apply one RUN-state clock edge to the model using the currently driven inputs.
    function automatic void model_step();
        bit pred = m_pred(F_PC_i);
        int li, h, gi, ci;
        if (D_update_i) begin
            li = lidx(D_PC_i);
            h  = m_lht[li];
            m_lpht[h] = bump(m_lpht[h], D_taken_i);
            m_lht[li] = (h * 2 + int'(D_taken_i)) % 256;
            gi = gidx(int'(D_ghr_i), D_PC_i);
            m_gpht[gi] = bump(m_gpht[gi], D_taken_i);
            ci = cidx(D_PC_i);
            if (D_train_local_taken_i != D_train_global_taken_i)
                m_ch[ci] = bump(m_ch[ci], D_train_global_taken_i);
            m_br++;
            if (!D_train_taken_i) m_mis++;
        end
        if (D_update_i && !D_train_taken_i) m_ghr = (int'(D_ghr_i) * 2 + int'(D_taken_i)) % 256;
        else if (F_fire_i)                  m_ghr = (m_ghr * 2 + int'(pred)) % 256;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit fire, input logic [31:0] fpc, input bit upd, input logic [31:0] dpc,
                         input logic [7:0] dghr, input bit taken, input bit tt, input bit tl, input bit tg);
        F_fire_i = fire;  F_PC_i = fpc;  D_update_i = upd;  D_PC_i = dpc;  D_ghr_i = dghr;
        D_taken_i = taken;  D_train_taken_i = tt;
        D_train_local_taken_i = tl;  D_train_global_taken_i = tg;
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(0, fpc, 0, 32'h0, 8'h0, 0, 1, 1, 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"},  F_ready_o,          1);
        check({tag, "_local"},  F_local_predict_o,  m_local(F_PC_i));
        check({tag, "_global"}, F_global_predict_o, m_global(F_PC_i));
        check({tag, "_pred"},   F_predict_o,        m_pred(F_PC_i));
        check({tag, "_ghr"},    F_ghr_o,            m_ghr);
        check({tag, "_pbr"},    D_perf_branch_o,    exp_perf(m_br));
        check({tag, "_pmis"},   D_perf_mispred_o,   exp_perf(m_mis));
    endtask

    task automatic cycle_check(input string tag);
        @(negedge clk);
        check_model(tag);
        tick();
    endtask

    // Counts edges until ready while hammering fire/update, which INIT must ignore.
    task automatic wait_ready(input string name);
        int cnt = 0;
        drive(1, 32'h0000_0104, 1, 32'h0000_0104, 8'hA5, 1, 0, 0, 1);
        while (!F_ready_o && cnt < 1000) begin
            if (cnt == 10) begin
                check({name, "_init_pred"}, {F_predict_o, F_local_predict_o, F_global_predict_o}, 0);
                check({name, "_init_ghr"}, F_ghr_o, 0);
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        idle(32'h0);
        check(name, cnt, INIT_CYCLES);
    endtask

    typedef struct {
        bit          fire;
        logic [31:0] fpc;
        bit          upd;
        logic [31:0] dpc;
        logic [7:0]  dghr;
        bit          taken, tt, tl, tg;
        bit          e_pred, e_loc, e_glob;
        logic [7:0]  e_ghr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fresh tables; PC 0x100 maps to LHT 0, gshare 0x40 (GHR 0), chooser 0x40.
        vecs[0] = '{0, 32'h100, 0, 32'h000, 8'h00, 0, 1, 1, 1, 0, 0, 0, 8'h00};
        vecs[1] = '{0, 32'h100, 1, 32'h100, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[2] = '{0, 32'h100, 1, 32'h100, 8'h00, 1, 1, 0, 0, 0, 0, 1, 8'h00};
        vecs[3] = '{0, 32'h100, 1, 32'h100, 8'h00, 1, 1, 0, 0, 0, 0, 1, 8'h00};
        vecs[4] = '{0, 32'h100, 0, 32'h000, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'h00};
        vecs[5] = '{0, 32'h100, 1, 32'h204, 8'h2D, 0, 0, 1, 1, 0, 0, 1, 8'h00};
        vecs[6] = '{1, 32'h100, 1, 32'h208, 8'h33, 0, 0, 1, 1, 0, 0, 0, 8'h5A};
        vecs[7] = '{0, 32'h100, 0, 32'h000, 8'h00, 0, 1, 1, 1, 0, 0, 0, 8'h66};
        vecs[8] = '{1, 32'h100, 0, 32'h000, 8'h00, 0, 1, 1, 1, 0, 0, 0, 8'h66};
        vecs[9] = '{0, 32'h100, 0, 32'h000, 8'h00, 0, 1, 1, 1, 0, 0, 0, 8'hCC};

        rst = 1'b1;
        idle(32'h0);
        #12;
        check("rst_ready", F_ready_o, 0);
        check("rst_ghr", F_ghr_o, 0);
        check("rst_perf", {D_perf_branch_o | D_perf_mispred_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_ready("init_len");
        cycle_check("post_init");

        // Directed table: history-indexed local, gshare training, GHR repair vs fetch shift.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fire, vecs[i].fpc, vecs[i].upd, vecs[i].dpc, vecs[i].dghr,
                  vecs[i].taken, vecs[i].tt, vecs[i].tl, vecs[i].tg);
            @(negedge clk);
            check($sformatf("vec%0d_pred", i),   F_predict_o,        vecs[i].e_pred);
            check($sformatf("vec%0d_local", i),  F_local_predict_o,  vecs[i].e_loc);
            check($sformatf("vec%0d_global", i), F_global_predict_o, vecs[i].e_glob);
            check($sformatf("vec%0d_ghr", i),    F_ghr_o,            vecs[i].e_ghr);
            tick();
        end

        // Chooser at PC 0x40 (entry 0x10): saturate toward local, hold, then walk to global.
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h40, 1, 32'h40, 8'h00, 1, 1, 1, 0);
            cycle_check("ch_loc");
        end
        drive(0, 32'h40, 1, 32'h40, 8'h00, 1, 1, 1, 1);
        cycle_check("ch_both");
        drive(0, 32'h40, 1, 32'h40, 8'hCC, 1, 1, 1, 1);
        cycle_check("ch_gtrain");
        idle(32'h40);
        @(negedge clk);
        check("chooser_sat_local_glob", F_global_predict_o, 1);
        check("chooser_sat_local_pred", F_predict_o, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h40, 1, 32'h40, 8'hCC, 1, 1, 0, 1);
            cycle_check("ch_glob");
        end
        idle(32'h40);
        @(negedge clk);
        check("chooser_to_global_pred", F_predict_o, 1);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 1), ($urandom & 32'hF000_03FC), $urandom_range(0, 1),
                  ($urandom & 32'h0F00_03FC), 8'($urandom), $urandom_range(0, 1),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1));
            cycle_check("rand");
        end

        // Performance counters: 10 resolved branches, 3 of them mispredicted.
        begin
            int b0 = m_br;
            int m0 = m_mis;
            for (int i = 0; i < 10; i++) begin
                drive(0, 32'h0, 1, ($urandom & 32'h3FC), 8'($urandom), $urandom_range(0, 1),
                      !(i == 2 || i == 5 || i == 7), $urandom_range(0, 1), $urandom_range(0, 1));
                cycle_check("perf");
            end
            idle(32'h0);
            @(negedge clk);
            check("perf_branch_10", D_perf_branch_o, exp_perf(b0 + 10));
            check("perf_mispred_3", D_perf_mispred_o, exp_perf(m0 + 3));
            tick();
        end

        // Reset mid-RUN, then again mid-INIT: INIT must restart and all state clear.
        F_PC_i = 32'h100;
        rst = 1'b1;
        #1;
        check("rst_run_ready", F_ready_o, 0);
        check("rst_run_ghr", F_ghr_o, 0);
        check("rst_run_pred", {F_predict_o, F_local_predict_o, F_global_predict_o}, 0);
        check("rst_run_perf", {D_perf_branch_o | D_perf_mispred_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid_init_ready", F_ready_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_ready("reinit_len");
        for (int i = 0; i < 16; i++) begin
            idle(($urandom & 32'h3FC));
            cycle_check("reinit");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
